// File: rtl/dbg_cmd_port.sv
// rtl/dbg_cmd_port.sv - byte-stream debug command responder driving the core's GP and dmem debug ports
//
// Purpose: accepts host commands one byte at a time, halts/resumes the core,
// reads/writes GP registers and data memory through the core's debug ports,
// and returns a byte-stream response.
//
// Ports:
//   iw_clk, iw_rst                  clock, synchronous active-high reset
//   iw_cmd_valid/iw_cmd_data/ow_cmd_ready   command byte channel (host -> port)
//   ow_rsp_valid/ow_rsp_data/iw_rsp_ready   response byte channel (port -> host)
//   ow_halt, iw_halted              halt request / core drained-and-stalled status
//   ow_gp_we/ow_gp_addr/ow_gp_wdata, iw_gp_rdata      GP register debug port
//   ow_mem_we/ow_mem_addr/ow_mem_wdata, iw_mem_rdata  dmem debug port (1-cycle read)
//
// Optional: define DBG_CMD_STEP_EN to accept opcode 0x03 (single step).

module dbg_cmd_port #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 12,
  parameter int GP_N   = 16
) (
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic              iw_cmd_valid,
  input  logic [7:0]        iw_cmd_data,
  output logic              ow_cmd_ready,
  output logic              ow_rsp_valid,
  output logic [7:0]        ow_rsp_data,
  input  logic              iw_rsp_ready,
  output logic              ow_halt,
  input  logic              iw_halted,
  output logic              ow_gp_we,
  output logic [3:0]        ow_gp_addr,
  output logic [DATA_W-1:0] ow_gp_wdata,
  input  logic [DATA_W-1:0] iw_gp_rdata,
  output logic              ow_mem_we,
  output logic [ADDR_W-1:0] ow_mem_addr,
  output logic [DATA_W-1:0] ow_mem_wdata,
  input  logic [DATA_W-1:0] iw_mem_rdata
);

  localparam int NB    = (DATA_W + 7) / 8;
  localparam int DW8   = NB * 8;
  // Room for the longest argument list: 2 address bytes + NB data bytes.
  localparam int ARG_W = DW8 + 16;

  localparam logic [7:0] RSP_OK   = 8'hA5;
  localparam logic [7:0] RSP_BUSY = 8'hEB;
  localparam logic [7:0] RSP_BAD  = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE, S_ARG, S_ACC, S_WAIT, S_RSP
`ifdef DBG_CMD_STEP_EN
    , S_STEP, S_SWAIT
`endif
  } state_t;

  state_t state_q, state_d;

  logic [7:0]        op_q;
  logic [7:0]        cnt_q;
  logic [ARG_W-1:0]  arg_q;
  logic [ARG_W-1:0]  arg_next;
  logic [DW8-1:0]    rsp_q;
  logic [7:0]        rsp_n_q;
  logic              halt_q;
  logic [3:0]        gp_addr_q;
  logic [DATA_W-1:0] gp_wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              cmd_ready;
  logic              gp_we;
  logic              mem_we;
  logic              unused_arg;

  function automatic logic is_rdgp(input logic [7:0] op);
    return (op[7:4] == 4'h1) && (int'(op[3:0]) < GP_N);
  endfunction

  function automatic logic is_wrgp(input logic [7:0] op);
    return (op[7:4] == 4'h2) && (int'(op[3:0]) < GP_N);
  endfunction

  function automatic logic is_rdmem(input logic [7:0] op);
    return op == 8'h30;
  endfunction

  function automatic logic is_wrmem(input logic [7:0] op);
    return op == 8'h40;
  endfunction

  function automatic logic is_step(input logic [7:0] op);
`ifdef DBG_CMD_STEP_EN
    return op == 8'h03;
`else
    return (op == 8'h03) && 1'b0;
`endif
  endfunction

  function automatic logic needs_core(input logic [7:0] op);
    return is_rdgp(op) || is_wrgp(op) || is_rdmem(op) || is_wrmem(op);
  endfunction

  function automatic logic is_known(input logic [7:0] op);
    return (op == 8'h01) || (op == 8'h02) || needs_core(op) || is_step(op);
  endfunction

  function automatic logic [7:0] arg_count(input logic [7:0] op);
    if (is_wrgp(op))  return 8'(NB);
    if (is_rdmem(op)) return 8'd2;
    if (is_wrmem(op)) return 8'(NB + 2);
    return 8'd0;
  endfunction

  // Single-byte responses sit in the top byte so they leave first.
  function automatic logic [DW8-1:0] one_byte(input logic [7:0] b);
    return DW8'(b) << (DW8 - 8);
  endfunction

  assign arg_next   = {arg_q[ARG_W-9:0], iw_cmd_data};
  // Shifted-out and ignored address bits are intentionally dropped.
  assign unused_arg = ^{arg_q, arg_next};

  always_ff @(posedge iw_clk) begin
    if (iw_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    gp_we     = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (iw_cmd_valid) begin
          if (!is_known(iw_cmd_data))            state_d = S_RSP;
          else if (arg_count(iw_cmd_data) != 0)  state_d = S_ARG;
          else                                   state_d = S_ACC;
        end
      end
      S_ARG: begin
        cmd_ready = 1'b1;
        if (iw_cmd_valid && cnt_q == 8'd1) state_d = S_ACC;
      end
      S_ACC: begin
        gp_we  = is_wrgp(op_q) && iw_halted;
        mem_we = is_wrmem(op_q) && iw_halted;
        if (needs_core(op_q) && !iw_halted)   state_d = S_RSP;
        else if (is_rdmem(op_q))              state_d = S_WAIT;
`ifdef DBG_CMD_STEP_EN
        else if (is_step(op_q) && halt_q)     state_d = S_STEP;
`endif
        else                                  state_d = S_RSP;
      end
      S_WAIT: state_d = S_RSP;
      S_RSP: begin
        if (iw_rsp_ready && rsp_n_q == 8'd1) state_d = S_IDLE;
      end
`ifdef DBG_CMD_STEP_EN
      S_STEP:  state_d = S_SWAIT;
      S_SWAIT: if (iw_halted) state_d = S_RSP;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      op_q        <= '0;
      cnt_q       <= '0;
      arg_q       <= '0;
      rsp_q       <= '0;
      rsp_n_q     <= '0;
      halt_q      <= 1'b0;
      gp_addr_q   <= '0;
      gp_wdata_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (iw_cmd_valid) begin
            op_q  <= iw_cmd_data;
            cnt_q <= arg_count(iw_cmd_data);
            arg_q <= '0;
            if (is_rdgp(iw_cmd_data) || is_wrgp(iw_cmd_data)) gp_addr_q <= iw_cmd_data[3:0];
            if (!is_known(iw_cmd_data)) begin
              rsp_q   <= one_byte(RSP_BAD);
              rsp_n_q <= 8'd1;
            end
          end
        end
        S_ARG: begin
          if (iw_cmd_valid) begin
            arg_q <= arg_next;
            cnt_q <= cnt_q - 8'd1;
            // Publish the assembled arguments as the last byte lands so the
            // strobe in ACC sees final address and data.
            if (cnt_q == 8'd1) begin
              if (is_wrgp(op_q))  gp_wdata_q <= arg_next[DATA_W-1:0];
              if (is_rdmem(op_q)) mem_addr_q <= arg_next[ADDR_W-1:0];
              if (is_wrmem(op_q)) begin
                mem_addr_q  <= arg_next[DW8 +: ADDR_W];
                mem_wdata_q <= arg_next[DATA_W-1:0];
              end
            end
          end
        end
        S_ACC: begin
          rsp_n_q <= 8'd1;
          if (needs_core(op_q) && !iw_halted) begin
            rsp_q <= one_byte(RSP_BUSY);
          end else if (op_q == 8'h01) begin
            halt_q <= 1'b1;
            rsp_q  <= one_byte(RSP_OK);
          end else if (op_q == 8'h02) begin
            halt_q <= 1'b0;
            rsp_q  <= one_byte(RSP_OK);
          end else if (is_rdgp(op_q)) begin
            rsp_q   <= DW8'(iw_gp_rdata);
            rsp_n_q <= 8'(NB);
          end else if (is_step(op_q)) begin
            if (halt_q) halt_q <= 1'b0;
            else        rsp_q  <= one_byte(RSP_BUSY);
          end else begin
            rsp_q <= one_byte(RSP_OK);
          end
        end
        S_WAIT: begin
          rsp_q   <= DW8'(iw_mem_rdata);
          rsp_n_q <= 8'(NB);
        end
        S_RSP: begin
          if (iw_rsp_ready) begin
            rsp_q   <= rsp_q << 8;
            rsp_n_q <= rsp_n_q - 8'd1;
          end
        end
`ifdef DBG_CMD_STEP_EN
        S_STEP: halt_q <= 1'b1;
        S_SWAIT: begin
          if (iw_halted) begin
            rsp_q   <= one_byte(RSP_OK);
            rsp_n_q <= 8'd1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign ow_cmd_ready = cmd_ready & ~iw_rst;
  assign ow_rsp_valid = (state_q == S_RSP) & ~iw_rst;
  assign ow_rsp_data  = rsp_q[DW8-1 -: 8];
  assign ow_halt      = halt_q;
  assign ow_gp_we     = gp_we & ~iw_rst;
  assign ow_mem_we    = mem_we & ~iw_rst;
  assign ow_gp_addr   = gp_addr_q;
  assign ow_gp_wdata  = gp_wdata_q;
  assign ow_mem_addr  = mem_addr_q;
  assign ow_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dbg_cmd_port.sv
// tb/tb_dbg_cmd_port.sv - self-checking bench for dbg_cmd_port
module tb_dbg_cmd_port;
  localparam int DATA_W = 24;
  localparam int ADDR_W = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cmd_valid, cmd_ready, rsp_valid, rsp_ready, halt, halted, gp_we, mem_we;
  logic [7:0] cmd_data, rsp_data;
  logic [3:0] gp_addr;
  logic [DATA_W-1:0] gp_wdata, gp_rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  dbg_cmd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .GP_N(16)) dut (
    .iw_clk(clk), .iw_rst(rst),
    .iw_cmd_valid(cmd_valid), .iw_cmd_data(cmd_data), .ow_cmd_ready(cmd_ready),
    .ow_rsp_valid(rsp_valid), .ow_rsp_data(rsp_data), .iw_rsp_ready(rsp_ready),
    .ow_halt(halt), .iw_halted(halted),
    .ow_gp_we(gp_we), .ow_gp_addr(gp_addr), .ow_gp_wdata(gp_wdata), .iw_gp_rdata(gp_rdata),
    .ow_mem_we(mem_we), .ow_mem_addr(mem_addr), .ow_mem_wdata(mem_wdata), .iw_mem_rdata(mem_rdata)
  );

  // Core stub: register file with combinational read, dmem with 1-cycle read.
  logic [DATA_W-1:0] core_gp [16] = '{default: '0};
  logic [DATA_W-1:0] core_mem [4096] = '{default: '0};
  assign gp_rdata = core_gp[gp_addr];
  always @(posedge clk) begin
    mem_rdata <= core_mem[mem_addr];
    if (gp_we)  core_gp[gp_addr]   <= gp_wdata;
    if (mem_we) core_mem[mem_addr] <= mem_wdata;
  end

  // Strobe monitor.
  int gp_we_n = 0, mem_we_n = 0, bad_strobe = 0;
  logic [3:0] mon_gp_addr;
  logic [DATA_W-1:0] mon_gp_wdata, mon_mem_wdata;
  logic [ADDR_W-1:0] mon_mem_addr;
  always @(negedge clk) begin
    if (!rst) begin
      if (gp_we) begin
        gp_we_n++; mon_gp_addr = gp_addr; mon_gp_wdata = gp_wdata;
        if (!halted) bad_strobe++;
      end
      if (mem_we) begin
        mem_we_n++; mon_mem_addr = mem_addr; mon_mem_wdata = mem_wdata;
        if (!halted) bad_strobe++;
      end
    end
  end

  int vectors = 0, miscompares = 0;

  // Reference model state.
  bit m_halt = 1'b0;
  logic [DATA_W-1:0] m_gp [16] = '{default: '0};
  logic [DATA_W-1:0] m_mem [4096] = '{default: '0};
  logic [7:0] cmd_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int exp_gp_we, exp_mem_we, exp_lat, lat_obs;
  bit send_ok, stable_ok;

  task automatic push_word(input logic [DATA_W-1:0] w);
    exp_q.push_back(w[23:16]); exp_q.push_back(w[15:8]); exp_q.push_back(w[7:0]);
  endtask

  // Expected outcome of the command in cmd_q, from the command set's rules.
  task automatic model_cmd();
    logic [7:0] op;
    logic [15:0] a16;
    logic [ADDR_W-1:0] a;
    op = cmd_q[0];
    exp_q = {}; exp_gp_we = 0; exp_mem_we = 0; exp_lat = 1;
    if (op == 8'h01) begin m_halt = 1'b1; exp_q.push_back(8'hA5); end
    else if (op == 8'h02) begin m_halt = 1'b0; exp_q.push_back(8'hA5); end
    else if (!(op[7:4] == 4'h1 || op[7:4] == 4'h2 || op == 8'h30 || op == 8'h40)) exp_q.push_back(8'hEE);
    else if (!halted) exp_q.push_back(8'hEB);
    else if (op[7:4] == 4'h1) push_word(m_gp[op[3:0]]);
    else if (op[7:4] == 4'h2) begin
      m_gp[op[3:0]] = {cmd_q[1], cmd_q[2], cmd_q[3]};
      exp_gp_we = 1; exp_q.push_back(8'hA5);
    end else begin
      a16 = {cmd_q[1], cmd_q[2]};
      a = a16[ADDR_W-1:0];
      if (op == 8'h30) begin push_word(m_mem[a]); exp_lat = 2; end
      else begin
        m_mem[a] = {cmd_q[3], cmd_q[4], cmd_q[5]};
        exp_mem_we = 1; exp_q.push_back(8'hA5);
      end
    end
  endtask

  function automatic logic [63:0] pack(input logic [7:0] q[$]);
    logic [63:0] r;
    r = '0;
    r[63:56] = 8'(q.size());
    for (int i = 0; i < q.size() && i < 7; i++) r[55:0] = {r[47:0], q[i]};
    return r;
  endfunction

  // Starts and ends at a negedge; ends on the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    cmd_valid = 1'b1; cmd_data = b;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (!cmd_ready) send_ok = 1'b0;
    else @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic recv(input int n, input int stall);
    int waited;
    bit stalled;
    logic [7:0] hold;
    waited = 0; stalled = (stall == 0); stable_ok = 1'b1;
    got_q = {}; lat_obs = -1;
    rsp_ready = stalled;
    while (got_q.size() < n && waited < 100) begin
      if (rsp_valid) begin
        if (lat_obs < 0) lat_obs = waited;
        if (!stalled) begin
          hold = rsp_data;
          for (int k = 0; k < stall; k++) begin
            @(negedge clk); waited++;
            if (!rsp_valid || rsp_data !== hold) stable_ok = 1'b0;
          end
          stalled = 1'b1; rsp_ready = 1'b1;
        end
        got_q.push_back(rsp_data);
      end
      @(negedge clk); waited++;
    end
    rsp_ready = 1'b0;
  endtask

  task automatic do_cmd(input int stall);
    send_ok = 1'b1;
    foreach (cmd_q[i]) send_byte(cmd_q[i]);
    recv(exp_q.size(), stall);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cmd_ready, rsp_valid, rsp_data, halt, gp_we, gp_addr, gp_wdata, mem_we, mem_addr, mem_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h required=0",
               {cmd_ready, rsp_valid, rsp_data, halt, gp_we, gp_addr, gp_wdata, mem_we, mem_addr, mem_wdata});
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset ready=%b valid=%b required ready=1 valid=0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_halt();
    halted = 1'b1;
    cmd_q = '{8'h01}; model_cmd(); do_cmd(0);
    vectors++;
    if (!send_ok || pack(got_q) !== pack(exp_q)) begin
      miscompares++; $display("FAIL halt_rsp got=%h required=%h", pack(got_q), pack(exp_q));
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (halt !== 1'b1) begin miscompares++; $display("FAIL halt_held got=%b required=1", halt); end
  endtask

  task automatic test_gp();
    int n0;
    n0 = gp_we_n;
    cmd_q = '{8'h25, 8'h12, 8'h34, 8'h56}; model_cmd(); do_cmd(0);
    vectors++;
    if (!send_ok || pack(got_q) !== pack(exp_q) || lat_obs != 1) begin
      miscompares++; $display("FAIL wrgp_rsp got=%h lat=%0d required=%h lat=1", pack(got_q), lat_obs, pack(exp_q));
    end
    vectors++;
    if (gp_we_n - n0 != 1 || mon_gp_addr !== 4'h5 || mon_gp_wdata !== 24'h123456) begin
      miscompares++;
      $display("FAIL wrgp_strobe n=%0d addr=%h data=%h required n=1 addr=5 data=123456", gp_we_n - n0, mon_gp_addr, mon_gp_wdata);
    end
    cmd_q = '{8'h15}; model_cmd(); do_cmd(0);
    vectors++;
    if (!send_ok || pack(got_q) !== pack(exp_q) || lat_obs != 1) begin
      miscompares++; $display("FAIL rdgp_rsp got=%h lat=%0d required=%h lat=1", pack(got_q), lat_obs, pack(exp_q));
    end
  endtask

  task automatic test_mem();
    int n0;
    n0 = mem_we_n;
    cmd_q = '{8'h40, 8'h0F, 8'hFF, 8'hAB, 8'hCD, 8'hEF}; model_cmd(); do_cmd(0);
    vectors++;
    if (!send_ok || pack(got_q) !== pack(exp_q) || lat_obs != 1) begin
      miscompares++; $display("FAIL wrmem_rsp got=%h lat=%0d required=%h lat=1", pack(got_q), lat_obs, pack(exp_q));
    end
    vectors++;
    if (mem_we_n - n0 != 1 || mon_mem_addr !== 12'hFFF || mon_mem_wdata !== 24'hABCDEF) begin
      miscompares++;
      $display("FAIL wrmem_strobe n=%0d addr=%h data=%h required n=1 addr=fff data=abcdef", mem_we_n - n0, mon_mem_addr, mon_mem_wdata);
    end
    cmd_q = '{8'h30, 8'h0F, 8'hFF}; model_cmd(); do_cmd(0);
    vectors++;
    if (!send_ok || pack(got_q) !== pack(exp_q) || lat_obs != 2) begin
      miscompares++; $display("FAIL rdmem_rsp got=%h lat=%0d required=%h lat=2", pack(got_q), lat_obs, pack(exp_q));
    end
  endtask

  task automatic test_not_halted();
    int n0;
    halted = 1'b0;
    n0 = gp_we_n;
    cmd_q = '{8'h23, 8'h01, 8'h02, 8'h03}; model_cmd(); do_cmd(0);
    vectors++;
    if (!send_ok || pack(got_q) !== pack(exp_q)) begin
      miscompares++; $display("FAIL busy_rsp sent_all=%b got=%h required=%h", send_ok, pack(got_q), pack(exp_q));
    end
    vectors++;
    if (gp_we_n != n0 || bad_strobe != 0) begin
      miscompares++; $display("FAIL busy_no_strobe pulses=%0d bad=%0d required 0 0", gp_we_n - n0, bad_strobe);
    end
    halted = 1'b1;
  endtask

  task automatic test_unknown();
    cmd_q = '{8'h7F}; model_cmd(); do_cmd(0);
    vectors++;
    if (!send_ok || pack(got_q) !== pack(exp_q)) begin
      miscompares++; $display("FAIL unknown_rsp got=%h required=%h", pack(got_q), pack(exp_q));
    end
`ifndef DBG_CMD_STEP_EN
    cmd_q = '{8'h03}; model_cmd(); do_cmd(0);
    vectors++;
    if (!send_ok || pack(got_q) !== pack(exp_q)) begin
      miscompares++; $display("FAIL step_disabled_rsp got=%h required=%h", pack(got_q), pack(exp_q));
    end
`endif
    cmd_q = '{8'h02}; model_cmd(); do_cmd(0);
    vectors++;
    if (!send_ok || pack(got_q) !== pack(exp_q) || halt !== 1'b0) begin
      miscompares++; $display("FAIL resume_after_unknown got=%h halt=%b required=%h halt=0", pack(got_q), halt, pack(exp_q));
    end
    cmd_q = '{8'h01}; model_cmd(); do_cmd(0);
  endtask

  task automatic test_backpressure();
    cmd_q = '{8'h15}; model_cmd(); do_cmd(10);
    vectors++;
    if (!stable_ok) begin miscompares++; $display("FAIL stall_stable got=0 required=1"); end
    vectors++;
    if (!send_ok || pack(got_q) !== pack(exp_q)) begin
      miscompares++; $display("FAIL stall_rsp got=%h required=%h", pack(got_q), pack(exp_q));
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    bit quiet;
    n0 = gp_we_n;
    send_ok = 1'b1;
    send_byte(8'h21); send_byte(8'hAA); send_byte(8'hBB);
    rst = 1'b1;
    @(negedge clk);
    m_halt = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || halt !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid valid=%b halt=%b required 0 0", rsp_valid, halt);
    end
    rst = 1'b0;
    quiet = 1'b1;
    repeat (4) begin @(negedge clk); if (rsp_valid !== 1'b0 || gp_we !== 1'b0) quiet = 1'b0; end
    vectors++;
    if (!quiet || gp_we_n != n0) begin
      miscompares++; $display("FAIL reset_mid_quiet quiet=%b pulses=%0d required 1 0", quiet, gp_we_n - n0);
    end
    cmd_q = '{8'h01}; model_cmd(); do_cmd(0);
    vectors++;
    if (!send_ok || pack(got_q) !== pack(exp_q) || halt !== 1'b1) begin
      miscompares++; $display("FAIL halt_after_reset got=%h halt=%b required=%h halt=1", pack(got_q), halt, pack(exp_q));
    end
  endtask

  task automatic test_random();
    int k, g0, m0;
    logic [7:0] op;
    logic [15:0] a16;
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 6);
      halted = ($urandom_range(0, 3) != 0);
      a16 = 16'($urandom);
      a16[ADDR_W-1:0] = 12'($urandom_range(0, 7)) | (($urandom_range(0, 1) != 0) ? 12'hFF8 : 12'h0);
      case (k)
        0: cmd_q = '{8'h01};
        1: cmd_q = '{8'h02};
        2: cmd_q = '{8'h10 | 8'($urandom_range(0, 15))};
        3: cmd_q = '{8'h20 | 8'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 8'($urandom)};
        4: cmd_q = '{8'h30, a16[15:8], a16[7:0]};
        5: cmd_q = '{8'h40, a16[15:8], a16[7:0], 8'($urandom), 8'($urandom), 8'($urandom)};
        default: begin
          do op = 8'($urandom);
          while (op == 8'h01 || op == 8'h02 || op[7:4] == 4'h1 || op[7:4] == 4'h2 || op == 8'h30 || op == 8'h40
`ifdef DBG_CMD_STEP_EN
                 || op == 8'h03
`endif
                 );
          cmd_q = '{op};
        end
      endcase
      g0 = gp_we_n; m0 = mem_we_n;
      model_cmd(); do_cmd(0);
      vectors++;
      if (!send_ok || pack(got_q) !== pack(exp_q)) begin
        miscompares++; $display("FAIL rand_rsp i=%0d op=%h got=%h required=%h", i, cmd_q[0], pack(got_q), pack(exp_q));
      end
      vectors++;
      if (gp_we_n - g0 != exp_gp_we || mem_we_n - m0 != exp_mem_we || halt !== m_halt) begin
        miscompares++;
        $display("FAIL rand_side i=%0d gp=%0d mem=%0d halt=%b required %0d %0d %b",
                 i, gp_we_n - g0, mem_we_n - m0, halt, exp_gp_we, exp_mem_we, m_halt);
      end
    end
    vectors++;
    if (bad_strobe != 0) begin miscompares++; $display("FAIL strobe_while_running got=%0d required=0", bad_strobe); end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; rsp_ready = 1'b0; halted = 1'b1;
    @(negedge clk);
    test_reset();
    test_halt();
    test_gp();
    test_mem();
    test_not_halted();
    test_unknown();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
